// File: rtl/arbitro_envia_serial_if.sv
// Handshake bundle between the two requesting control units, the serial
// transmitter and the arbiter that shares it.
interface arbitro_envia_serial_if;
    logic       envia_menu;
    logic [7:0] dados_menu;
    logic       envia_jogo;
    logic [7:0] dados_jogo;
    logic       tx_pronto;
    logic       tx_partida;
    logic [7:0] tx_dados;
    logic       fim_envia_menu;
    logic       fim_envia_jogo;
    logic       erro_tx;
    logic       ocupado;
    logic [2:0] db_estado;

    modport slave (
        input  envia_menu, dados_menu, envia_jogo, dados_jogo, tx_pronto,
        output tx_partida, tx_dados, fim_envia_menu, fim_envia_jogo,
        erro_tx, ocupado, db_estado
    );

    modport master (
        output envia_menu, dados_menu, envia_jogo, dados_jogo, tx_pronto,
        input  tx_partida, tx_dados, fim_envia_menu, fim_envia_jogo,
        erro_tx, ocupado, db_estado
    );
endinterface

// File: rtl/arbitro_envia_serial.sv
// Round-robin arbiter sharing one serial transmitter between the menu and
// base-game control units, with timeout watchdog and inter-byte idle gap.
module arbitro_envia_serial #(
    parameter int unsigned GAP_CICLOS     = 4,
    parameter int unsigned TIMEOUT_CICLOS = 65535
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    arbitro_envia_serial_if.slave  bus
);
    localparam logic [15:0] TMO_ULT = 16'(TIMEOUT_CICLOS - 1);
    localparam logic [15:0] GAP_ULT = (GAP_CICLOS > 0) ? 16'(GAP_CICLOS - 1) : 16'd0;
    localparam logic        TEM_GAP = (GAP_CICLOS > 0);
    localparam logic        DONO_MENU = 1'b0;
    localparam logic        DONO_JOGO = 1'b1;

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        CONCEDE   = 3'd1,
        ESPERA_TX = 3'd2,
        FINALIZA  = 3'd3,
        INTERVALO = 3'd4
    } estado_t;

    estado_t     estado_q, estado_d;
    logic        pend_menu_q, pend_menu_d, pend_jogo_q, pend_jogo_d;
    logic [7:0]  buf_menu_q, buf_menu_d, buf_jogo_q, buf_jogo_d;
    logic        ultimo_q, ultimo_d, dono_q, dono_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d, gap_cnt_q, gap_cnt_d;
    logic        tx_partida_q, tx_partida_d;
    logic [7:0]  tx_dados_q, tx_dados_d;
    logic        fim_menu_q, fim_menu_d, fim_jogo_q, fim_jogo_d;
    logic        erro_tx_q, erro_tx_d, ocupado_q, ocupado_d;
    logic        grant_menu_s, grant_jogo_s;

    // Next-state, arbitration and request-latch logic; all outputs are precomputed here.
    always_comb begin
        estado_d     = estado_q;
        ultimo_d     = ultimo_q;
        dono_d       = dono_q;
        tmo_cnt_d    = tmo_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        tx_dados_d   = tx_dados_q;
        tx_partida_d = 1'b0;
        fim_menu_d   = 1'b0;
        fim_jogo_d   = 1'b0;
        erro_tx_d    = 1'b0;
        grant_menu_s = 1'b0;
        grant_jogo_s = 1'b0;
        case (estado_q)
            OCIOSO: begin
                // On a tie the requester that was not served last wins.
                if (pend_menu_q && (!pend_jogo_q || (ultimo_q == DONO_JOGO))) begin
                    grant_menu_s = 1'b1;
                    estado_d     = CONCEDE;
                    tx_dados_d   = buf_menu_q;
                    dono_d       = DONO_MENU;
                    ultimo_d     = DONO_MENU;
                    tx_partida_d = 1'b1;
                end else if (pend_jogo_q) begin
                    grant_jogo_s = 1'b1;
                    estado_d     = CONCEDE;
                    tx_dados_d   = buf_jogo_q;
                    dono_d       = DONO_JOGO;
                    ultimo_d     = DONO_JOGO;
                    tx_partida_d = 1'b1;
                end else begin
                    estado_d = OCIOSO;
                end
            end
            CONCEDE: begin
                tmo_cnt_d = 16'd0;
                estado_d  = ESPERA_TX;
            end
            ESPERA_TX: begin
                tmo_cnt_d = tmo_cnt_q + 16'd1;
                if (bus.tx_pronto || (tmo_cnt_q == TMO_ULT)) begin
                    estado_d   = FINALIZA;
                    fim_menu_d = (dono_q == DONO_MENU);
                    fim_jogo_d = (dono_q == DONO_JOGO);
                    erro_tx_d  = !bus.tx_pronto;
                end else begin
                    estado_d = ESPERA_TX;
                end
            end
            FINALIZA: begin
                if (TEM_GAP) begin
                    estado_d  = INTERVALO;
                    gap_cnt_d = 16'd0;
                end else begin
                    estado_d = OCIOSO;
                end
            end
            INTERVALO: begin
                if (gap_cnt_q == GAP_ULT) begin
                    estado_d = OCIOSO;
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            default: estado_d = OCIOSO;
        endcase

        // A new request in the granting cycle re-arms the latch with fresh data.
        pend_menu_d = pend_menu_q;
        buf_menu_d  = buf_menu_q;
        if (bus.envia_menu && (!pend_menu_q || grant_menu_s)) begin
            pend_menu_d = 1'b1;
            buf_menu_d  = bus.dados_menu;
        end else if (grant_menu_s) begin
            pend_menu_d = 1'b0;
        end else begin
            pend_menu_d = pend_menu_q;
        end

        pend_jogo_d = pend_jogo_q;
        buf_jogo_d  = buf_jogo_q;
        if (bus.envia_jogo && (!pend_jogo_q || grant_jogo_s)) begin
            pend_jogo_d = 1'b1;
            buf_jogo_d  = bus.dados_jogo;
        end else if (grant_jogo_s) begin
            pend_jogo_d = 1'b0;
        end else begin
            pend_jogo_d = pend_jogo_q;
        end

        ocupado_d = (estado_d != OCIOSO) || pend_menu_d || pend_jogo_d;
    end

    // State, latches, counters and registered outputs.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            estado_q     <= OCIOSO;
            pend_menu_q  <= 1'b0;
            pend_jogo_q  <= 1'b0;
            buf_menu_q   <= 8'h00;
            buf_jogo_q   <= 8'h00;
            ultimo_q     <= DONO_JOGO;
            dono_q       <= DONO_MENU;
            tmo_cnt_q    <= 16'd0;
            gap_cnt_q    <= 16'd0;
            tx_partida_q <= 1'b0;
            tx_dados_q   <= 8'h00;
            fim_menu_q   <= 1'b0;
            fim_jogo_q   <= 1'b0;
            erro_tx_q    <= 1'b0;
            ocupado_q    <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            pend_menu_q  <= pend_menu_d;
            pend_jogo_q  <= pend_jogo_d;
            buf_menu_q   <= buf_menu_d;
            buf_jogo_q   <= buf_jogo_d;
            ultimo_q     <= ultimo_d;
            dono_q       <= dono_d;
            tmo_cnt_q    <= tmo_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            tx_partida_q <= tx_partida_d;
            tx_dados_q   <= tx_dados_d;
            fim_menu_q   <= fim_menu_d;
            fim_jogo_q   <= fim_jogo_d;
            erro_tx_q    <= erro_tx_d;
            ocupado_q    <= ocupado_d;
        end
    end

    assign bus.tx_partida     = tx_partida_q;
    assign bus.tx_dados       = tx_dados_q;
    assign bus.fim_envia_menu = fim_menu_q;
    assign bus.fim_envia_jogo = fim_jogo_q;
    assign bus.erro_tx        = erro_tx_q;
    assign bus.ocupado        = ocupado_q;
    assign bus.db_estado      = estado_q;
endmodule

// File: tb/tb_arbitro_envia_serial.sv
// Self-checking bench for arbitro_envia_serial: directed scenarios plus
// randomized rounds checked against a round-robin transaction model.
module tb_arbitro_envia_serial;
    localparam int GAP = 4;
    localparam int TMO = 10;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   fim_seen = 0;
    bit   last_menu;

    arbitro_envia_serial_if bus ();

    arbitro_envia_serial #(.GAP_CICLOS(GAP), .TIMEOUT_CICLOS(TMO)) dut (
        .clock_i   (clk),
        .reset_n_i (reset_n),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_3(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs == exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Completion pulses must never overlap; also counts every pulse seen.
    always @(negedge clk) begin
        if (bus.fim_envia_menu || bus.fim_envia_jogo) fim_seen++;
        if (reset_n) chk_b("fim_exclusive", bus.fim_envia_menu & bus.fim_envia_jogo, 1'b0);
    end

    // Wait (bounded) for a start pulse, check it, answer after 'delay' cycles.
    task automatic serve(input bit owner_menu, input logic [7:0] exp_d, input int exp_p,
                         input int delay, output int fim_cyc);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (bus.tx_partida === 1'b1) seen = 1'b1;
            else tick();
        end
        chk_b("partida_seen", seen, 1'b1);
        if (exp_p >= 0) chk_i("partida_cycle", cyc, exp_p);
        chk_8("tx_dados_start", bus.tx_dados, exp_d);
        repeat (delay) tick();
        bus.tx_pronto = 1'b1;
        tick();
        bus.tx_pronto = 1'b0;
        chk_b("fim_menu", bus.fim_envia_menu, owner_menu);
        chk_b("fim_jogo", bus.fim_envia_jogo, !owner_menu);
        chk_b("erro_ok", bus.erro_tx, 1'b0);
        chk_8("tx_dados_end", bus.tx_dados, exp_d);
        last_menu = owner_menu;
        fim_cyc = cyc;
    endtask

    initial begin
        int c, p, f, f2, f3, mask, d1, d2, fim_before;
        bit first_menu;
        logic [7:0] dm, dj;

        bus.envia_menu = 1'b0; bus.dados_menu = 8'h00;
        bus.envia_jogo = 1'b0; bus.dados_jogo = 8'h00;
        bus.tx_pronto  = 1'b0;
        last_menu = 1'b0;

        // Reset state
        tick(); tick();
        chk_b("rst_partida", bus.tx_partida, 1'b0);
        chk_b("rst_fim_menu", bus.fim_envia_menu, 1'b0);
        chk_b("rst_fim_jogo", bus.fim_envia_jogo, 1'b0);
        chk_b("rst_erro", bus.erro_tx, 1'b0);
        chk_b("rst_ocupado", bus.ocupado, 1'b0);
        chk_8("rst_tx_dados", bus.tx_dados, 8'h00);
        chk_3("rst_estado", bus.db_estado, 3'd0);
        reset_n = 1'b1;
        tick();

        // Single menu request; tx_pronto during CONCEDE must be ignored
        bus.envia_menu = 1'b1; bus.dados_menu = 8'hF4; c = cyc;
        tick();
        bus.envia_menu = 1'b0; bus.dados_menu = 8'h00;
        chk_b("s1_no_early_start", bus.tx_partida, 1'b0);
        chk_b("s1_ocupado", bus.ocupado, 1'b1);
        tick();
        chk_b("s1_partida", bus.tx_partida, 1'b1);
        chk_8("s1_dados", bus.tx_dados, 8'hF4);
        bus.tx_pronto = 1'b1;
        tick();
        bus.tx_pronto = 1'b0;
        chk_3("s1_pronto_ignored", bus.db_estado, 3'd2);
        tick(); tick();
        bus.tx_pronto = 1'b1;
        tick();
        bus.tx_pronto = 1'b0;
        chk_i("s1_fim_cycle", cyc - c, 6);
        chk_b("s1_fim_menu", bus.fim_envia_menu, 1'b1);
        chk_b("s1_fim_jogo", bus.fim_envia_jogo, 1'b0);
        chk_b("s1_erro", bus.erro_tx, 1'b0);
        tick();
        chk_b("s1_fim_width", bus.fim_envia_menu, 1'b0);
        chk_3("s1_gap_state", bus.db_estado, 3'd4);
        repeat (GAP) tick();
        chk_3("s1_idle", bus.db_estado, 3'd0);
        chk_b("s1_idle_ocupado", bus.ocupado, 1'b0);

        // Simultaneous requests after reset: menu wins first tie
        reset_n = 1'b0; last_menu = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        bus.envia_menu = 1'b1; bus.dados_menu = 8'hF1;
        bus.envia_jogo = 1'b1; bus.dados_jogo = 8'h2A; c = cyc;
        tick();
        bus.envia_menu = 1'b0; bus.envia_jogo = 1'b0;
        serve(1'b1, 8'hF1, c + 2, 3, f);
        serve(1'b0, 8'h2A, f + GAP + 2, 2, f);
        repeat (GAP + 1) tick();

        // Fairness under continuous requests
        bus.envia_menu = 1'b1; bus.dados_menu = 8'hC3;
        bus.envia_jogo = 1'b1; bus.dados_jogo = 8'h3C; c = cyc;
        tick();
        p = c + 2;
        for (int i = 0; i < 10; i++) begin
            if (i == 8) begin
                bus.envia_menu = 1'b0; bus.envia_jogo = 1'b0;
            end
            first_menu = !last_menu;
            serve(first_menu, first_menu ? 8'hC3 : 8'h3C, p, 1 + (i % 3), f);
            chk_b("fair_alternate", first_menu, (i % 2) == 0);
            p = f + GAP + 2;
        end
        repeat (GAP + 1) tick();
        chk_b("fair_drained", bus.ocupado, 1'b0);

        // Timeout on a jogo byte
        bus.envia_jogo = 1'b1; bus.dados_jogo = 8'h77;
        tick();
        bus.envia_jogo = 1'b0;
        tick();
        chk_b("tmo_partida", bus.tx_partida, 1'b1);
        chk_8("tmo_dados", bus.tx_dados, 8'h77);
        repeat (TMO) tick();
        chk_b("tmo_not_yet", bus.fim_envia_jogo, 1'b0);
        tick();
        chk_b("tmo_fim_jogo", bus.fim_envia_jogo, 1'b1);
        chk_b("tmo_erro", bus.erro_tx, 1'b1);
        chk_b("tmo_fim_menu", bus.fim_envia_menu, 1'b0);
        tick();
        chk_b("tmo_fim_width", bus.fim_envia_jogo, 1'b0);
        chk_b("tmo_erro_clear", bus.erro_tx, 1'b0);
        repeat (GAP) tick();
        chk_3("tmo_idle", bus.db_estado, 3'd0);
        last_menu = 1'b0;

        // Duplicate request ignored; request on the grant edge re-arms
        bus.envia_jogo = 1'b1; bus.dados_jogo = 8'h55;
        tick();
        bus.envia_jogo = 1'b0;
        tick();
        chk_b("dup_partida_jogo", bus.tx_partida, 1'b1);
        bus.envia_menu = 1'b1; bus.dados_menu = 8'hF4;
        tick();
        bus.dados_menu = 8'hF0;
        tick();
        bus.envia_menu = 1'b0;
        bus.tx_pronto = 1'b1;
        tick();
        bus.tx_pronto = 1'b0;
        chk_b("dup_fim_jogo", bus.fim_envia_jogo, 1'b1);
        repeat (GAP + 1) tick();
        chk_3("dup_grant_cycle", bus.db_estado, 3'd0);
        bus.envia_menu = 1'b1; bus.dados_menu = 8'hF3;
        tick();
        bus.envia_menu = 1'b0;
        serve(1'b1, 8'hF4, cyc, 2, f2);
        serve(1'b1, 8'hF3, f2 + GAP + 2, 3, f3);
        repeat (GAP + 1) tick();
        chk_b("dup_idle", bus.ocupado, 1'b0);

        // Asynchronous reset while waiting for the transmitter
        bus.envia_menu = 1'b1; bus.dados_menu = 8'hA5;
        tick();
        bus.envia_menu = 1'b0;
        tick();
        chk_b("ar_partida", bus.tx_partida, 1'b1);
        tick(); tick();
        fim_before = fim_seen;
        #2;
        reset_n = 1'b0;
        #1;
        chk_3("ar_estado", bus.db_estado, 3'd0);
        chk_b("ar_ocupado", bus.ocupado, 1'b0);
        chk_8("ar_tx_dados", bus.tx_dados, 8'h00);
        chk_b("ar_fim_menu", bus.fim_envia_menu, 1'b0);
        bus.tx_pronto = 1'b1;
        tick(); tick();
        bus.tx_pronto = 1'b0;
        reset_n = 1'b1; last_menu = 1'b0;
        repeat (3) tick();
        chk_i("ar_no_fim", fim_seen, fim_before);
        chk_3("ar_idle", bus.db_estado, 3'd0);
        bus.envia_menu = 1'b1; bus.dados_menu = 8'hF4; c = cyc;
        tick();
        bus.envia_menu = 1'b0;
        serve(1'b1, 8'hF4, c + 2, 3, f);
        chk_i("ar_fim_cycle", f - c, 6);
        repeat (GAP + 1) tick();

        // Randomized rounds against the round-robin model
        for (int r = 0; r < 16; r++) begin
            mask = $urandom_range(1, 3);
            dm = 8'($urandom);
            dj = 8'($urandom);
            d1 = $urandom_range(1, TMO);
            d2 = $urandom_range(1, TMO);
            repeat ($urandom_range(0, 3)) tick();
            bus.envia_menu = mask[0]; bus.dados_menu = dm;
            bus.envia_jogo = mask[1]; bus.dados_jogo = dj; c = cyc;
            tick();
            bus.envia_menu = 1'b0; bus.envia_jogo = 1'b0;
            if (mask == 3) begin
                first_menu = !last_menu;
                serve(first_menu, first_menu ? dm : dj, c + 2, d1, f);
                serve(!first_menu, first_menu ? dj : dm, f + GAP + 2, d2, f);
            end else begin
                serve(mask == 1, (mask == 1) ? dm : dj, c + 2, d1, f);
            end
            repeat (GAP + 1) tick();
            chk_b("rnd_idle", bus.ocupado, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end
endmodule
